// File: rtl/score_pkg.sv
// Shared constants, register map and FSM encoding for the score/BCD controller.
package score_pkg;

  localparam int SCORE_W = 14;
  localparam int DIGITS  = 4;
  localparam int BCD_W   = 4 * DIGITS;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

  // APB register offsets (PADDR[11:0])
  localparam logic [11:0] ADDR_SCORE  = 12'h000;
  localparam logic [11:0] ADDR_CTRL   = 12'h004;
  localparam logic [11:0] ADDR_DIGITS = 12'h008;
  localparam logic [11:0] ADDR_HIGH   = 12'h00C;

  localparam int CTRL_CLR_BIT  = 0;
  localparam int CTRL_FRZ_BIT  = 1;
  localparam int STAT_FRZ_BIT  = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] v);
    return (v > SCORE_MAX) ? SCORE_MAX : v;
  endfunction

endpackage

// File: rtl/score_bcd_ctrl_if.sv
// APB3 bus bundle between the Cortex-M3 fabric (master) and the score controller (slave).
// Zero-wait-state protocol: a transfer is a setup cycle (PSEL & !PENABLE) followed by one
// access cycle (PSEL & PENABLE); PREADY is always 1 so every access completes in that cycle.
interface score_bcd_ctrl_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: start captures the binary value, done is high during the
// cycle whose closing edge performs the last of SCORE_W shifts; bcd then holds the result.
module bin2bcd_seq
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  logic [SCORE_W-1:0] bin_sr;
  logic [3:0]         cnt;
  logic               running;
  logic [BCD_W-1:0]   adj;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  assign done = running && (cnt == 4'(SCORE_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr  <= '0;
      bcd     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      bin_sr  <= bin;
      bcd     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      bcd     <= {adj[BCD_W-2:0], bin_sr[SCORE_W-1]};
      bin_sr  <= {bin_sr[SCORE_W-2:0], 1'b0};
      cnt     <= cnt + 4'd1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/score_bcd_ctrl.sv
// Score controller: APB register file, clear/load/hit arbitration with saturation, and a
// once-per-frame BCD conversion FSM. Define SCORE_HIGH_EN to build the high-score register.
module score_bcd_ctrl
  import score_pkg::*;
(
  input  logic                 PCLK,
  input  logic                 PRESERN,
  score_bcd_ctrl_if.slave      apb,
  input  logic                 hit,
  input  logic                 frame_start,
  output logic [BCD_W-1:0]     digits,
  output logic                 busy,
  output logic                 overflow,
  output state_t               dbg_state
);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               dirty_q, freeze_q, overflow_q, overflow_d, busy_q;
  logic [BCD_W-1:0]   digits_q;
  logic [11:0]        addr;
  logic               wr_stb, do_clear, do_load, hit_ok;
  logic               conv_start, conv_done, commit;
  logic [BCD_W-1:0]   conv_bcd;
  logic [31:0]        rd_data;
  logic               unused_apb_bits;

  assign addr            = apb.PADDR[11:0];
  assign unused_apb_bits = ^{apb.PADDR[31:12], apb.PWDATA[31:SCORE_W]};
  assign apb.PREADY      = 1'b1;
  assign apb.PSLVERR     = 1'b0;

  assign wr_stb   = apb.PSEL && apb.PENABLE && apb.PWRITE;
  assign do_clear = wr_stb && (addr == ADDR_CTRL) && apb.PWDATA[CTRL_CLR_BIT];
  assign do_load  = wr_stb && (addr == ADDR_SCORE);
  // A hit loses to any register update landing in the same cycle.
  assign hit_ok   = hit && !freeze_q && !do_clear && !do_load;

  always_comb begin
    score_d    = score_q;
    overflow_d = overflow_q;
    if (do_clear) begin
      score_d    = '0;
      overflow_d = 1'b0;
    end else if (do_load) begin
      score_d    = clamp_score(apb.PWDATA[SCORE_W-1:0]);
      overflow_d = 1'b0;
    end else if (hit_ok) begin
      if (score_q == SCORE_MAX) overflow_d = 1'b1;
      else                      score_d    = score_q + 14'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE:   if (frame_start && dirty_q) state_d = ST_LOAD;
      ST_LOAD: begin
        conv_start = 1'b1;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT:  if (conv_done) state_d = ST_COMMIT;
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // The converter registers score_q on conv_start, which is the frame snapshot.
  bin2bcd_seq u_bin2bcd (
    .clk   (PCLK),
    .rst_n (PRESERN),
    .start (conv_start),
    .bin   (score_q),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      overflow_q <= 1'b0;
      freeze_q   <= 1'b0;
      dirty_q    <= 1'b0;
      busy_q     <= 1'b0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      overflow_q <= overflow_d;
      if (wr_stb && (addr == ADDR_CTRL)) freeze_q <= apb.PWDATA[CTRL_FRZ_BIT];
      // A change racing the snapshot edge must survive, so it wins over the LOAD clear.
      if (score_d != score_q)       dirty_q <= 1'b1;
      else if (state_q == ST_LOAD)  dirty_q <= 1'b0;
      // busy stays up for the cycle after COMMIT so it covers the full 17-cycle latency.
      busy_q     <= (state_d != ST_IDLE) || (state_q == ST_COMMIT);
      if (commit) digits_q <= conv_bcd;
    end
  end

`ifdef SCORE_HIGH_EN
  logic [SCORE_W-1:0] high_q;
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN)             high_q <= '0;
    else if (score_q > high_q) high_q <= score_q;
  end
`endif

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_SCORE:  rd_data[SCORE_W-1:0] = score_q;
      ADDR_CTRL: begin
        rd_data[STAT_FRZ_BIT]  = freeze_q;
        rd_data[STAT_BUSY_BIT] = busy_q;
        rd_data[STAT_OVF_BIT]  = overflow_q;
      end
      ADDR_DIGITS: rd_data[BCD_W-1:0] = digits_q;
`ifdef SCORE_HIGH_EN
      ADDR_HIGH:   rd_data[SCORE_W-1:0] = high_q;
`endif
      default:     rd_data = '0;
    endcase
  end

  // Read data is captured in the setup phase and held through the access phase.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN)                         apb.PRDATA <= '0;
    else if (apb.PSEL && !apb.PENABLE)    apb.PRDATA <= rd_data;
  end

  assign digits    = digits_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: doc/score_bcd_ctrl.md
# score_bcd_ctrl

Score-keeping controller between the game logic, the Cortex-M3 APB bus and the pixel renderer. It arbitrates score updates from CPU writes and tile-hit pulses, and saturates the score at 9999. Once per frame it runs a serial binary-to-BCD conversion and presents frame-stable decimal digits to the score-drawing logic.

## Interface
- SCORE_W, 14: binary score width.
- DIGITS, 4: BCD digits produced.
- SCORE_MAX, 9999: saturation value.
- PCLK  in  1  system clock.
- PRESERN  in  1  reset, asynchronous, active-low.
- PSEL, PENABLE, PWRITE  in  1  APB3 control.
- PADDR  in  32  APB address; only PADDR[11:0] decoded.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  tied 0.
- hit  in  1  one-cycle pulse per correctly struck tile.
- frame_start  in  1  one-cycle pulse at the start of each video frame.
- digits  out  4*DIGITS  BCD digits; digit 0 in [3:0]; changes only at COMMIT.
- busy  out  1  conversion in progress.
- overflow  out  1  sticky; a hit arrived while score = SCORE_MAX.

## Operation
- Write strobe: PSEL & PENABLE & PWRITE.
- Register map:
  - 0x000 SCORE: RW. A write loads PWDATA[13:0], clamped to SCORE_MAX.
  - 0x004 CTRL/STATUS. Write: bit0 clear (self-clearing), bit1 freeze. Read: {29'b0, overflow, busy, freeze}.
  - 0x008 DIGITS: RO, zero-extended.
  - 0x00C HIGH: RO.
  - Any other address reads 0; writes to it are ignored.
- Update priority per cycle: clear > SCORE load > hit. A hit coinciding with clear or load is discarded.
- A hit while freeze=1 is discarded.
- A hit at SCORE_MAX leaves the score unchanged and sets overflow. Clear and load both reset overflow.
- Any score change sets dirty.
- FSM states: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE -> LOAD when frame_start & dirty. frame_start with dirty=0, or while not in IDLE, is ignored.
  - LOAD: snapshot the score, clear dirty, zero the BCD shift register -> SHIFT.
  - SHIFT: SCORE_W double-dabble iterations (add 3 to each nibble >= 5, then shift left 1) -> COMMIT.
  - COMMIT: digits <= BCD result -> IDLE.
- A score change during conversion sets dirty again. It is picked up at the next frame_start; the current snapshot is unaffected.
- PRDATA is registered in the APB setup phase (PSEL & !PENABLE) and holds through the access phase.

## Timing
- Reset values: score 0, dirty 0, freeze 0, overflow 0, state IDLE, busy 0, digits 0, PRDATA 0, high 0.
- Asserting reset mid-conversion aborts the conversion immediately. digits returns to 0.
- Score update: new value is visible one edge after the strobe or hit.
- Conversion timeline, with frame_start sampled at edge N:
  - LOAD occupies N+1.
  - SHIFT occupies N+2..N+15.
  - COMMIT at N+16; digits valid after edge N+16.
- busy is high after edge N through edge N+16.
- Conversion latency is 17 cycles. This is far below one frame, so at most one conversion runs per frame.
- APB: zero wait states. No transfer is ever stalled by conversion.

## Configuration
- SCORE_HIGH_EN defined: a high-score register tracks the maximum score reached.
  - Updated the cycle after the score exceeds it.
  - Survives clear and load; reset only by PRESERN.
  - Read at 0x00C.
- SCORE_HIGH_EN undefined: no register is built and 0x00C reads 0.

## Structure
- score_pkg holds:
  - register offsets (0x000/0x004/0x008/0x00C);
  - SCORE_MAX;
  - CTRL bit positions;
  - FSM state encoding.
- Sub-module bin2bcd_seq holds the serial double-dabble engine: start/done handshake, SCORE_W-cycle shift.
- The top level holds the APB decode, update arbitration and the FSM.

## Test plan
- Reset, then 37 hit pulses, then frame_start: digits = 0x0037 at edge N+16; busy is high for exactly 17 cycles.
- Write SCORE=9998, then 3 hits: score = 9999, overflow = 1, STATUS reads 0x4; after a frame, digits = 0x9999.
- SCORE write and hit on the same cycle: the written value is kept and the hit is lost. With freeze=1, 5 hits leave the score unchanged.
- Hit during SHIFT: digits commit the old snapshot. The next frame_start converts the new value. A second frame_start during busy is ignored.
- Write SCORE=12345: the score clamps to 9999. Reads of 0x010 return 0. PREADY=1 and PSLVERR=0 throughout.
- Assert PRESERN mid-SHIFT: all outputs return to their reset values asynchronously. With SCORE_HIGH_EN: score 50, clear, score 20 → HIGH reads 50.
